// File: rtl/noc_mux_rr.sv
// ----------------------------------------------------------------------------
// noc_mux_rr -- N-to-1 packet multiplexer for the NoC flit interface.
//
// Merges CHANNELS input flit streams onto one registered output link.
// Arbitration is round-robin at packet granularity: once a channel wins with
// a non-last flit, it keeps the grant until its last flit has transferred,
// so packets from different sources are never interleaved.
//
// Flit format: bit FLIT_WIDTH-1 = first-flit marker,
//              bit FLIT_WIDTH-2 = last-flit marker.
//
// Build option: define NOC_MUX_ERRCHK_EN to enable the sticky marker
// consistency checker on err. Without it err is tied low.
// ----------------------------------------------------------------------------
module noc_mux_rr #(
   parameter int FLIT_WIDTH = 34,
   parameter int CHANNELS   = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
   input  logic [CHANNELS-1:0]            in_valid,
   output logic [CHANNELS-1:0]            in_ready,
   output logic [FLIT_WIDTH-1:0]          out_flit,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           err
);

   // Pointer / channel-index width; at least one bit so CHANNELS=1 still builds.
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Elaboration-time guard on the supported channel range.
   generate
      if ((CHANNELS < 1) || (CHANNELS > 8)) begin : g_bad_channels
         $error("noc_mux_rr: CHANNELS must be in 1..8");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // State registers and their next-state values
   // -------------------------------------------------------------------------
   state_t                 state_q,     state_d;
   logic [CH_W-1:0]        rr_q,        rr_d;
   logic [CH_W-1:0]        lock_q,      lock_d;
   logic [FLIT_WIDTH-1:0]  out_flit_q,  out_flit_d;
   logic                   out_valid_q, out_valid_d;

   // -------------------------------------------------------------------------
   // Combinational helpers
   // -------------------------------------------------------------------------
   logic                   can_load_s;
   logic                   win_found_s;
   logic [CH_W-1:0]        win_idx_s;
   logic [CH_W-1:0]        sel_s;
   logic                   grant_act_s;
   logic [FLIT_WIDTH-1:0]  sel_flit_s;
   logic [CHANNELS-1:0]    in_ready_s;
   logic                   xfer_s;
   logic                   last_s;

   // Output stage can accept a new flit when empty or draining this cycle.
   always_comb begin
      can_load_s = (!out_valid_q) || out_ready;
   end

   // Round-robin search: first valid channel starting at rr_q, wrapping.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = {CH_W{1'b0}};
      for (int k = 0; k < CHANNELS; k++) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!win_found_s && in_valid[i] &&
                (i == ((int'(rr_q) + k) % CHANNELS))) begin
               win_found_s = 1'b1;
               win_idx_s   = CH_W'(i);
            end else begin
               win_found_s = win_found_s;
               win_idx_s   = win_idx_s;
            end
         end
      end
   end

   // Granted channel: the lock owner while locked, else the round-robin winner.
   always_comb begin
      if (state_q == ST_LOCKED) begin
         sel_s       = lock_q;
         grant_act_s = 1'b1;
      end else begin
         sel_s       = win_idx_s;
         grant_act_s = win_found_s;
      end
   end

   // Select the granted channel's flit (constant slices only).
   always_comb begin
      sel_flit_s = {FLIT_WIDTH{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel_s == CH_W'(i)) begin
            sel_flit_s = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
         end else begin
            sel_flit_s = sel_flit_s;
         end
      end
   end

   // Ready only to the granted channel, only when the output can load,
   // and never while reset is asserted.
   always_comb begin
      in_ready_s = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready_s[i] = rst_n && grant_act_s && can_load_s &&
                         (sel_s == CH_W'(i));
      end
   end

   // A transfer happens on the granted channel when it is valid and ready.
   always_comb begin
      xfer_s = |(in_ready_s & in_valid);
      last_s = sel_flit_s[FLIT_WIDTH-2];
   end

   // Output register next value: load on transfer, drain on accept, else hold.
   always_comb begin
      out_flit_d  = out_flit_q;
      out_valid_d = out_valid_q;
      if (xfer_s) begin
         out_flit_d  = sel_flit_s;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Packet-tracking FSM next state: lock on a non-last winner flit,
   // release on a last flit; the rr pointer only advances from IDLE.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      lock_d  = lock_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer_s) begin
               if (win_idx_s == CH_W'(CHANNELS - 1)) begin
                  rr_d = {CH_W{1'b0}};
               end else begin
                  rr_d = win_idx_s + CH_W'(1);
               end
               if (!last_s) begin
                  state_d = ST_LOCKED;
                  lock_d  = win_idx_s;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (xfer_s && last_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Main state and output register bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_q        <= {CH_W{1'b0}};
         lock_q      <= {CH_W{1'b0}};
         out_flit_q  <= {FLIT_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         lock_q      <= lock_d;
         out_flit_q  <= out_flit_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef NOC_MUX_ERRCHK_EN
   // -------------------------------------------------------------------------
   // Marker consistency checker: an accepted flit must carry first=1 exactly
   // when it opens a packet (IDLE) and first=0 inside a packet (LOCKED).
   // -------------------------------------------------------------------------
   logic err_q, err_d;
   logic first_s;
   logic bad_marker_s;

   // Flag a first-marker that disagrees with the packet state.
   always_comb begin
      first_s = sel_flit_s[FLIT_WIDTH-1];
      if (state_q == ST_IDLE) begin
         bad_marker_s = xfer_s && !first_s;
      end else begin
         bad_marker_s = xfer_s && first_s;
      end
      err_d = err_q || bad_marker_s;
   end

   // Sticky error register, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign in_ready  = in_ready_s;
   assign out_flit  = out_flit_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_noc_mux_rr.sv
// ----------------------------------------------------------------------------
// tb_noc_mux_rr -- directed self-checking bench for noc_mux_rr (CHANNELS=3).
// Inputs change 1 time unit after a rising edge; in_ready is checked once
// inputs have settled and registered outputs 1 time unit after the next edge.
// ----------------------------------------------------------------------------
module tb_noc_mux_rr;

   localparam int FW = 34;
   localparam int CH = 3;

`ifdef NOC_MUX_ERRCHK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic [CH*FW-1:0]  in_flit;
   logic [CH-1:0]     in_valid;
   logic [CH-1:0]     in_ready;
   logic [FW-1:0]     out_flit;
   logic              out_valid;
   logic              out_ready;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;

   noc_mux_rr #(.FLIT_WIDTH(FW), .CHANNELS(CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_flit   (in_flit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_flit  (out_flit),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Single comparison point: counts and reports.
   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [FW-1:0] fl(input logic f, input logic l,
                                        input logic [31:0] p);
      return {f, l, p};
   endfunction

   task automatic set_ch(input int c, input logic v, input logic [FW-1:0] d);
      in_valid[c]         = v;
      in_flit[c*FW +: FW] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clock: check in_ready, clock, then check the output register.
   task automatic cyc(input string tag, input logic [CH-1:0] exp_rdy,
                      input logic exp_v, input logic [FW-1:0] exp_flit);
      #1;
      check_eq({tag, "_rdy"}, 64'(in_ready), 64'(exp_rdy));
      step();
      check_eq({tag, "_ov"}, 64'(out_valid), 64'(exp_v));
      if (exp_v) begin
         check_eq({tag, "_of"}, 64'(out_flit), 64'(exp_flit));
      end else begin
         n_checks = n_checks;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 3'b000;
      in_flit   = {(CH*FW){1'b0}};
      set_ch(0, 1'b1, fl(1'b1, 1'b1, 32'h1));
      set_ch(1, 1'b1, fl(1'b1, 1'b1, 32'h2));
      set_ch(2, 1'b1, fl(1'b1, 1'b1, 32'h3));

      // Reset: no ready, empty output even with all channels requesting.
      #1;
      check_eq("rst_rdy", 64'(in_ready), 64'(3'b000));
      check_eq("rst_ov", 64'(out_valid), 64'(1'b0));
      check_eq("rst_of", 64'(out_flit), 64'(0));
      check_eq("rst_err", 64'(err), 64'(1'b0));
      step();
      step();
      check_eq("rst_rdy2", 64'(in_ready), 64'(3'b000));
      check_eq("rst_ov2", 64'(out_valid), 64'(1'b0));
      rst_n = 1'b1;

      // Round-robin fairness with single-flit packets.
      cyc("rr0", 3'b001, 1'b1, fl(1'b1, 1'b1, 32'h1));
      cyc("rr1", 3'b010, 1'b1, fl(1'b1, 1'b1, 32'h2));
      cyc("rr2", 3'b100, 1'b1, fl(1'b1, 1'b1, 32'h3));
      cyc("rr3", 3'b001, 1'b1, fl(1'b1, 1'b1, 32'h1));
      cyc("rr4", 3'b010, 1'b1, fl(1'b1, 1'b1, 32'h2));
      cyc("rr5", 3'b100, 1'b1, fl(1'b1, 1'b1, 32'h3));
      in_valid = 3'b000;
      cyc("rr_drain", 3'b000, 1'b0, fl(1'b0, 1'b0, 32'h0));
      check_eq("rr_err", 64'(err), 64'(1'b0));

      // Packet locking: move rr to 1, then ch1 sends a 4-flit packet.
      set_ch(0, 1'b1, fl(1'b1, 1'b1, 32'h10));
      cyc("lk_pre", 3'b001, 1'b1, fl(1'b1, 1'b1, 32'h10));
      set_ch(0, 1'b1, fl(1'b1, 1'b1, 32'hC0));
      set_ch(2, 1'b1, fl(1'b1, 1'b1, 32'hC2));
      set_ch(1, 1'b1, fl(1'b1, 1'b0, 32'hA0));
      cyc("lk_a0", 3'b010, 1'b1, fl(1'b1, 1'b0, 32'hA0));
      set_ch(1, 1'b1, fl(1'b0, 1'b0, 32'hA1));
      cyc("lk_a1", 3'b010, 1'b1, fl(1'b0, 1'b0, 32'hA1));
      set_ch(1, 1'b1, fl(1'b0, 1'b0, 32'hA2));
      cyc("lk_a2", 3'b010, 1'b1, fl(1'b0, 1'b0, 32'hA2));
      set_ch(1, 1'b1, fl(1'b0, 1'b1, 32'hA3));
      cyc("lk_a3", 3'b010, 1'b1, fl(1'b0, 1'b1, 32'hA3));
      set_ch(1, 1'b0, fl(1'b0, 1'b0, 32'h0));
      cyc("lk_c2", 3'b100, 1'b1, fl(1'b1, 1'b1, 32'hC2));
      cyc("lk_c0", 3'b001, 1'b1, fl(1'b1, 1'b1, 32'hC0));
      in_valid = 3'b000;
      cyc("lk_drain", 3'b000, 1'b0, fl(1'b0, 1'b0, 32'h0));

      // Backpressure mid-packet on ch1 (rr now points at ch1).
      set_ch(1, 1'b1, fl(1'b1, 1'b0, 32'hB0));
      cyc("bp_b0", 3'b010, 1'b1, fl(1'b1, 1'b0, 32'hB0));
      set_ch(1, 1'b1, fl(1'b0, 1'b0, 32'hB1));
      out_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         cyc("bp_hold", 3'b000, 1'b1, fl(1'b1, 1'b0, 32'hB0));
      end
      out_ready = 1'b1;
      cyc("bp_b1", 3'b010, 1'b1, fl(1'b0, 1'b0, 32'hB1));
      set_ch(1, 1'b1, fl(1'b0, 1'b0, 32'hB2));
      cyc("bp_b2", 3'b010, 1'b1, fl(1'b0, 1'b0, 32'hB2));
      set_ch(1, 1'b1, fl(1'b0, 1'b1, 32'hB3));
      cyc("bp_b3", 3'b010, 1'b1, fl(1'b0, 1'b1, 32'hB3));
      in_valid = 3'b000;
      cyc("bp_drain", 3'b000, 1'b0, fl(1'b0, 1'b0, 32'h0));

      // Source stall: ch0 pauses mid-packet while ch1 waits.
      set_ch(1, 1'b1, fl(1'b1, 1'b1, 32'hD1));
      set_ch(0, 1'b1, fl(1'b1, 1'b0, 32'h50));
      cyc("st_s0", 3'b001, 1'b1, fl(1'b1, 1'b0, 32'h50));
      set_ch(0, 1'b1, fl(1'b0, 1'b0, 32'h51));
      cyc("st_s1", 3'b001, 1'b1, fl(1'b0, 1'b0, 32'h51));
      set_ch(0, 1'b0, fl(1'b0, 1'b0, 32'h0));
      for (int n = 0; n < 3; n++) begin
         cyc("st_gap", 3'b001, 1'b0, fl(1'b0, 1'b0, 32'h0));
      end
      set_ch(0, 1'b1, fl(1'b0, 1'b1, 32'h52));
      cyc("st_s2", 3'b001, 1'b1, fl(1'b0, 1'b1, 32'h52));
      set_ch(0, 1'b0, fl(1'b0, 1'b0, 32'h0));
      cyc("st_d1", 3'b010, 1'b1, fl(1'b1, 1'b1, 32'hD1));
      in_valid = 3'b000;
      cyc("st_drain", 3'b000, 1'b0, fl(1'b0, 1'b0, 32'h0));
      check_eq("st_err", 64'(err), 64'(1'b0));

      // Marker error: ch2 opens with first=0 while IDLE; still forwarded.
      set_ch(2, 1'b1, fl(1'b0, 1'b1, 32'hE2));
      cyc("er_e2", 3'b100, 1'b1, fl(1'b0, 1'b1, 32'hE2));
      check_eq("er_set", 64'(err), 64'(EXP_ERR));
      in_valid = 3'b000;
      cyc("er_drain", 3'b000, 1'b0, fl(1'b0, 1'b0, 32'h0));
      check_eq("er_hold", 64'(err), 64'(EXP_ERR));

      // Reset mid-packet: ch1 holds the lock, reset clears everything.
      set_ch(1, 1'b1, fl(1'b1, 1'b0, 32'h60));
      cyc("mr_m0", 3'b010, 1'b1, fl(1'b1, 1'b0, 32'h60));
      check_eq("mr_err", 64'(err), 64'(EXP_ERR));
      set_ch(1, 1'b1, fl(1'b0, 1'b0, 32'h61));
      set_ch(0, 1'b1, fl(1'b1, 1'b1, 32'h70));
      rst_n = 1'b0;
      #1;
      check_eq("mr_rdy", 64'(in_ready), 64'(3'b000));
      check_eq("mr_ov", 64'(out_valid), 64'(1'b0));
      check_eq("mr_of", 64'(out_flit), 64'(0));
      check_eq("mr_errclr", 64'(err), 64'(1'b0));
      step();
      rst_n = 1'b1;
      cyc("mr_n0", 3'b001, 1'b1, fl(1'b1, 1'b1, 32'h70));
      in_valid = 3'b000;
      cyc("mr_drain", 3'b000, 1'b0, fl(1'b0, 1'b0, 32'h0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_mux_rr.md
Name: noc_mux_rr

Overview:
- N-to-1 packet multiplexer for the NoC flit interface.
- Merges CHANNELS input flit streams onto one output link. Uses round-robin arbitration at packet granularity.
- Holds the grant for a channel from its first flit until its last flit, so packets are never interleaved.
- Registered output stage. Counterpart of the packet demultiplexer; used where several local sources share one router port.

Parameters:
- FLIT_WIDTH, 34, flit width. Bit FLIT_WIDTH-1 = first-flit marker, bit FLIT_WIDTH-2 = last-flit marker.
- CHANNELS, 3, number of input channels (1..8).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_flit  input  CHANNELS*FLIT_WIDTH  input flits; channel i at [i*FLIT_WIDTH +: FLIT_WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready
- out_flit  output  FLIT_WIDTH  output flit (registered)
- out_valid  output  1  output valid (registered)
- out_ready  input  1  downstream ready
- err  output  1  sticky protocol error flag (see Optional Feature)

Behaviour:
- Interface decision: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values:
  - out_valid=0, out_flit=0, err=0.
  - State IDLE, rr pointer=0, lock channel=0.
  - in_ready forced to all-0 while rst_n=0.
- Handshake:
  - A transfer occurs on a channel when valid&&ready are both high in the same cycle.
  - valid must not depend on ready; in_ready may depend combinationally on in_valid.
- Output register:
  - can_load = !out_valid || out_ready.
  - On an input transfer, out_flit/out_valid are loaded next edge; latency is 1 cycle.
  - If out_ready && out_valid and there is no input transfer, out_valid is cleared.
  - out_flit is held stable while out_valid && !out_ready.
  - Sustained throughput is 1 flit/cycle.
- State IDLE:
  - Winner = first channel with in_valid=1, searching from the rr pointer upward modulo CHANNELS.
  - in_ready[winner]=can_load; all other in_ready=0. No in_valid → all in_ready=0.
  - On transfer: rr pointer becomes (winner+1) mod CHANNELS.
  - If the flit's last bit=0: go to LOCKED and record winner as the lock channel.
  - If last=1 (single-flit packet): stay IDLE.
- State LOCKED:
  - in_ready[lock]=can_load; all others 0. The rr pointer is frozen.
  - Return to IDLE on transfer of a flit with last=1.
  - If the lock channel deasserts valid mid-packet, stay LOCKED. Other channels wait indefinitely; no timeout.
- Back-to-back packets:
  - A new packet can be granted in the cycle immediately after a last-flit transfer.
  - No bubble is inserted when out_ready=1.
- Simultaneous requests: at most one input transfer per cycle. The grant is decided by the rr pointer only.
- Markers:
  - Flit contents, including the markers, are forwarded unmodified.
  - Marker inconsistencies do not affect arbitration; only last=1 releases the lock.
- Reset mid-packet:
  - All state clears immediately (asynchronous).
  - The pending output flit is discarded; the next arbitration starts from channel 0.
- CHANNELS=1: behaves as a one-stage register slice with packet tracking.

Optional Feature:
- Macro: NOC_MUX_ERRCHK_EN.
- Defined: err is set, sticky until reset, when either:
  - an accepted flit in IDLE has first=0, or
  - an accepted flit in LOCKED has first=1.
  - Data is still forwarded unchanged.
- Undefined: err is tied to 0 and no checker logic is present.

Test Plan:
- Reset with CHANNELS=3, all in_valid=1 → in_ready=3'b000, out_valid=0 while rst_n=0. The first grant after release goes to ch0.
- Round-robin fairness:
  - Stimulus: ch0, ch1, ch2 each continuously offer single-flit packets (first=last=1), payloads 0x1/0x2/0x3; out_ready=1.
  - Required: out_flit payload sequence 1,2,3,1,2,3; one flit per cycle; out_valid first high one cycle after the first transfer.
- Packet locking:
  - Stimulus: ch1 sends a 4-flit packet 0xA0..0xA3 while ch0 and ch2 hold valid.
  - Required: output shows A0..A3 contiguously. The next grant goes to ch2, then ch0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles mid-packet.
  - Required: out_flit stable; all in_ready=0 after one flit is buffered; no flit lost or duplicated after out_ready=1.
- Source stall:
  - Stimulus: ch0 drops valid for 3 cycles between flits 2 and 3 of a packet while ch1 is valid.
  - Required: ch1 in_ready stays 0; the ch0 packet completes; ch1 is granted next.
- With NOC_MUX_ERRCHK_EN:
  - Stimulus: ch2 sends a flit with first=0 while IDLE.
  - Required: err=1 from the next cycle and held until rst_n=0; the flit is still forwarded.
  - Without the macro, the same stimulus leaves err=0.
